// File: rtl/bitcount_pkg.sv
// rtl/bitcount_pkg.sv - shared constants and gray encoder for param_bitcount
package bitcount_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Fixed 64-bit encoder; callers cast to their own width.
  function automatic logic [63:0] gray_encode(input logic [63:0] v);
    return v ^ (v >> 1);
  endfunction

endpackage

// File: rtl/bitcount_prescaler.sv
// rtl/bitcount_prescaler.sv - enable-gated divider producing one step per PRESCALE enabled clocks
module bitcount_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // With PRESCALE=1 the phase stays at 0 and step collapses to en.
  assign step = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/param_bitcount.sv
// rtl/param_bitcount.sv - up/down modulo counter with load, clear, prescaler, tc and ovf
// Optional gray output when PARAM_BITCOUNT_GRAY_EN is defined.
module param_bitcount
  import bitcount_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
`ifdef PARAM_BITCOUNT_GRAY_EN
  output logic [WIDTH-1:0] gray,
`endif
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic             step;
  logic [WIDTH-1:0] out_next;
  logic             tc_next;
  logic             ovf_next;

  bitcount_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clear | load),
    .step (step)
  );

  always_comb begin
    out_next = out;
    tc_next  = 1'b0;
    ovf_next = ovf;
    if (clear) begin
      out_next = '0;
      ovf_next = 1'b0;
    end else if (load) begin
      out_next = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step) begin
      if (dir == DIR_UP) begin
        if (out == MAX_V) begin
          out_next = '0;
          tc_next  = 1'b1;
          ovf_next = 1'b1;
        end else begin
          out_next = out + WIDTH'(1);
        end
      end else begin
        if (out == '0) begin
          out_next = MAX_V;
          tc_next  = 1'b1;
          ovf_next = 1'b1;
        end else begin
          out_next = out - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= out_next;
      tc  <= tc_next;
      ovf <= ovf_next;
    end
  end

`ifdef PARAM_BITCOUNT_GRAY_EN
  // Encoded from out_next so gray and out change on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) gray <= '0;
    else      gray <= WIDTH'(gray_encode(64'(out_next)));
  end
`endif

endmodule

// File: tb/tb_param_bitcount.sv
// tb/tb_param_bitcount.sv - directed self-checking bench for param_bitcount
module tb_param_bitcount;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en0 = 0, dir0 = 0, clear0 = 0, load0 = 0;
  logic [3:0] load_val0 = '0, out0;
  logic       tc0, ovf0;
  logic       en1 = 0, dir1 = 0, clear1 = 0, load1 = 0;
  logic [3:0] load_val1 = '0, out1;
  logic       tc1, ovf1;
  logic       en2 = 0, dir2 = 0, clear2 = 0, load2 = 0;
  logic [3:0] load_val2 = '0, out2;
  logic       tc2, ovf2;
`ifdef PARAM_BITCOUNT_GRAY_EN
  logic [3:0] gray0, gray1, gray2;
`endif

  param_bitcount u_def (
    .clk(clk), .rst(rst), .en(en0), .dir(dir0), .clear(clear0), .load(load0),
    .load_val(load_val0), .out(out0), .tc(tc0),
`ifdef PARAM_BITCOUNT_GRAY_EN
    .gray(gray0),
`endif
    .ovf(ovf0)
  );

  param_bitcount #(.WIDTH(4), .MAX(9), .PRESCALE(1)) u_mod10 (
    .clk(clk), .rst(rst), .en(en1), .dir(dir1), .clear(clear1), .load(load1),
    .load_val(load_val1), .out(out1), .tc(tc1),
`ifdef PARAM_BITCOUNT_GRAY_EN
    .gray(gray1),
`endif
    .ovf(ovf1)
  );

  param_bitcount #(.WIDTH(4), .MAX(15), .PRESCALE(4)) u_pre4 (
    .clk(clk), .rst(rst), .en(en2), .dir(dir2), .clear(clear2), .load(load2),
    .load_val(load_val2), .out(out2), .tc(tc2),
`ifdef PARAM_BITCOUNT_GRAY_EN
    .gray(gray2),
`endif
    .ovf(ovf2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_out;
    logic [3:0] prev_gray;
    int         k;
    logic [3:0] down_seq [4] = '{4'd2, 4'd1, 4'd0, 4'd9};

    // Reset state, held while rst is low
    tick();
    tick();
    check("rst_out", out0, 0);
    check("rst_tc", tc0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_out_mod10", out1, 0);
`ifdef PARAM_BITCOUNT_GRAY_EN
    check("rst_gray", gray0, 0);
    prev_gray = 4'd0;
`endif

    // Free-running up count through the 15->0 wrap
    rst = 1'b1;
    en0 = 1'b1;
    dir0 = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_out = 4'(i % 16);
      check($sformatf("up_out_%0d", i), out0, exp_out);
      check($sformatf("up_tc_%0d", i), tc0, (i == 16) ? 1 : 0);
      check($sformatf("up_ovf_%0d", i), ovf0, (i >= 16) ? 1 : 0);
`ifdef PARAM_BITCOUNT_GRAY_EN
      check($sformatf("gray_%0d", i), gray0, exp_out ^ (exp_out >> 1));
      check($sformatf("gray_1bit_%0d", i), $countones(gray0 ^ prev_gray), 1);
      prev_gray = gray0;
`endif
    end

    // Reach out=7 with ovf set, then clear and load together
    for (int i = 0; i < 6; i++) tick();
    check("pre_clear_out", out0, 7);
    check("pre_clear_ovf", ovf0, 1);
    clear0 = 1'b1;
    load0 = 1'b1;
    load_val0 = 4'd3;
    tick();
    check("clear_out", out0, 0);
    check("clear_ovf", ovf0, 0);
    check("clear_tc", tc0, 0);
    clear0 = 1'b0;
    load0 = 1'b0;

    // Asynchronous reset between edges at out=5
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_out", out0, 5);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", out0, 0);
    check("async_rst_tc", tc0, 0);
    check("async_rst_ovf", ovf0, 0);
    #2 rst = 1'b1;
    tick();
    check("post_rst_out", out0, 1);
    en0 = 1'b0;

    // MAX=9: load then count down through the 0->9 wrap
    dir1 = 1'b1;
    load1 = 1'b1;
    load_val1 = 4'd3;
    tick();
    check("m10_load_out", out1, 3);
    check("m10_load_tc", tc1, 0);
    load1 = 1'b0;
    en1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("m10_dn_out_%0d", i), out1, down_seq[i]);
      check($sformatf("m10_dn_tc_%0d", i), tc1, (i == 3) ? 1 : 0);
    end
    check("m10_ovf", ovf1, 1);
    tick();
    check("m10_tc_drop", tc1, 0);
    check("m10_after_out", out1, 8);
    en1 = 1'b0;
    load1 = 1'b1;
    load_val1 = 4'd12;
    tick();
    check("m10_clamp_out", out1, 9);
    check("m10_clamp_tc", tc1, 0);
    check("m10_clamp_ovf", ovf1, 1);
    load_val1 = 4'd8;
    tick();
    load1 = 1'b0;
    dir1 = 1'b0;
    en1 = 1'b1;
    tick();
    check("m10_up_out9", out1, 9);
    check("m10_up_tc9", tc1, 0);
    tick();
    check("m10_up_wrap_out", out1, 0);
    check("m10_up_wrap_tc", tc1, 1);
    en1 = 1'b0;
    tick();
    check("m10_en_off_tc", tc1, 0);
    check("m10_en_off_out", out1, 0);

    // PRESCALE=4: 12 enabled clocks with a 2-clock en=0 gap mid-phase
    k = 0;
    for (int i = 0; i < 14; i++) begin
      en2 = (i == 6 || i == 7) ? 1'b0 : 1'b1;
      if (en2) k++;
      tick();
      check($sformatf("pre_out_%0d", i), out2, k / 4);
      check($sformatf("pre_tc_%0d", i), tc2, 0);
    end
    check("pre_total", out2, 3);
    en2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_bitcount.md
Name: param_bitcount

Overview:
Parametrised successor to the fixed 4-bit free-running bit counter. Adds:
- configurable width and modulus
- up/down direction
- synchronous load and clear
- a clock-enable prescaler
- terminal-count pulse and sticky overflow flag

It is used as the general counting primitive in the lab designs, for display scan counters, timebases and event counters.

Parameters:
- WIDTH, 4, counter width in bits (≥1).
- MAX, 2**WIDTH-1, highest count value before wrap (1 ≤ MAX ≤ 2**WIDTH-1).
- PRESCALE, 1, number of enabled clocks per count step (≥1; 1 = step every enabled clock).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable; gates prescaler and counter.
- dir  input  1  0 = count up, 1 = count down.
- clear  input  1  synchronous clear of count, prescaler and overflow flag.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value loaded when load=1.
- out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle.
- ovf  output  1  sticky wrap flag, registered.

Behaviour:
- Reset (rst=0, asynchronous): out=0, tc=0, ovf=0, prescaler=0; held while rst=0; release takes effect at the next clk edge.
- Priority each edge: clear > load > step > hold.
- clear=1: out=0, prescaler=0, ovf=0, tc=0; en, dir and load are ignored.
- load=1 (clear=0):
  - out = load_val, clamped to MAX if load_val > MAX.
  - prescaler=0, tc=0, ovf unchanged.
  - Load never produces tc.
- Prescaler:
  - Internal counter 0..PRESCALE-1, advances only when en=1.
  - step = en && (prescaler == PRESCALE-1); on step the prescaler returns to 0.
  - For PRESCALE=1, step = en.
- Step, up (dir=0): out==MAX → out=0, tc=1, ovf=1; else out+1, tc=0.
- Step, down (dir=1): out==0 → out=MAX, tc=1, ovf=1; else out-1, tc=0.
- No step: out holds, tc=0.
- Latency: out and tc update on the same edge as the step. tc is high exactly in the cycle out shows the wrapped value.
- dir may change on any cycle; it is sampled only on step edges, and the prescaler phase is preserved.
- Arithmetic is modulo MAX+1. out never exceeds MAX under any input sequence.
- en=0 freezes prescaler and count; tc deasserts the next cycle.
- Reset mid-step: rst wins asynchronously; no partial update.

Optional Feature:
PARAM_BITCOUNT_GRAY_EN
- Defined:
  - adds output gray (WIDTH bits), registered, = out ^ (out >> 1), updated on the same edge as out.
  - reset value 0.
  - load/clear update it identically to out.
  - Gray property is guaranteed only when MAX = 2**WIDTH-1.
- Undefined: the gray port and its register are absent; all other behaviour is identical.

Decomposition:
- Package bitcount_pkg:
  - DIR_UP=1'b0, DIR_DOWN=1'b1 constants
  - gray-encode function used by the optional feature
- Sub-module bitcount_prescaler:
  - params PRESCALE
  - ports clk, rst, en, clr, step
  - clr driven by clear|load
- Counter, tc and ovf logic stay in param_bitcount.

Test Plan:
- Defaults (WIDTH=4, MAX=15, PRESCALE=1), en=1, dir=0 for 17 clocks from reset → out 1..15, 0, 1; tc high only on the edge where out=0; ovf=1 from then on.
- MAX=9, dir=1, load load_val=3 then en=1 → out 3,2,1,0,9; tc with out=9; load_val=12 load → out=9 (clamped), no tc.
- PRESCALE=4, en=1 for 12 clocks, en=0 for 2 clocks mid-phase → out increments once per 4 enabled clocks (3 total), with the phase preserved across the en=0 gap.
- Simultaneous clear=1, load=1, en=1 at out=7, ovf=1 → out=0, ovf=0, tc=0; clear wins.
- Drop rst low asynchronously between edges at out=5 with en=1 → out, tc, ovf go to 0 immediately; counting resumes from 0 after release.
- With PARAM_BITCOUNT_GRAY_EN defined, count up 0..15 → gray follows 0,1,3,2,6,…,8; exactly one bit changes per step, including the 15→0 wrap.
